config_loader: RTL
==================

# config_loader

Bitstream loader that drives the serial configuration chain formed by the fabric's connector boxes, switch boxes and CLBs. It accepts configuration words from a host-side source over a valid/ready handshake and serializes them LSB-first onto the chain's `config_in`. It qualifies each bit with `config_en` so every chain element shifts exactly once per bit. It counts exactly `CHAIN_LENGTH` bits, discards surplus bits of the final word, and reports completion.

## Interface
- `WORD_WIDTH`, 8: width of incoming configuration words.
- `CHAIN_LENGTH`, 64: total number of configuration bits in the chain; must be ≥ 1.
- `CNT_WIDTH`, `$clog2(CHAIN_LENGTH+1)`: bit-counter width.
- `BIT_WIDTH`, `$clog2(WORD_WIDTH+1)`: in-word bit-counter width.

Ports:
- `config_clk`  input  1  single clock for the loader and chain; all state updates on the rising edge.
- `sys_reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  begin a load; sampled only in IDLE or DONE.
- `word_in`  input  WORD_WIDTH  configuration word; bit 0 is shifted first.
- `word_valid`  input  1  `word_in` is valid.
- `word_ready`  output  1  loader accepts a word this cycle.
- `chain_data`  output  1  registered serial bit; connects to the first element's `config_in`.
- `chain_en`  output  1  registered shift enable; connects to the chain's `config_en`.
- `busy`  output  1  high in LOAD and SHIFT.
- `done`  output  1  high in DONE; held until the next `start`.
- `bits_sent`  output  CNT_WIDTH  number of bits shifted in the current or last load.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: all outputs low and `bits_sent` = 0. `start` moves the FSM to LOAD and clears `bits_sent`.
- LOAD:
  - `word_ready` = 1 and `chain_en` = 0.
  - A transfer occurs on `word_valid && word_ready`. On a transfer, `word_in` is captured into the shift register, the in-word counter is loaded with min(WORD_WIDTH, CHAIN_LENGTH − `bits_sent`), and the FSM moves to SHIFT.
  - While `word_valid` is low, the FSM waits indefinitely with the chain stalled. The chain holds its contents because `chain_en` = 0.
- SHIFT:
  - Each cycle: `chain_en` = 1, `chain_data` = current shift-register bit 0, the shift register shifts right by one, `bits_sent` increments, and the in-word counter decrements.
  - When the in-word counter reaches 0:
    - if `bits_sent` = CHAIN_LENGTH, go to DONE;
    - otherwise go to LOAD.
  - `word_ready` = 0 in SHIFT.
- Final word: only the low (CHAIN_LENGTH mod WORD_WIDTH) bits are shifted, or all WORD_WIDTH bits if the remainder is 0. Upper bits are discarded.
- DONE: `done` = 1 and `busy` = 0. `start` clears `done`, clears `bits_sent`, and moves to LOAD.
- Bit order on the chain: the first bit shifted ends at the far end of the chain after CHAIN_LENGTH shifts.
- `start` while `busy` is ignored.
- `word_valid` outside LOAD is ignored; no word is consumed.
- `sys_reset` asserted mid-load: the FSM returns to IDLE immediately and all outputs go low. The partial chain contents are left as-is; the next load rewrites the whole chain.
- `bits_sent` never exceeds CHAIN_LENGTH. The in-word counter never underflows.

## Timing
- Reset values: `word_ready` = 0, `chain_data` = 0, `chain_en` = 0, `busy` = 0, `done` = 0, `bits_sent` = 0, state = IDLE.
- `start` at edge N: LOAD is active from N; `word_ready` = 1 from cycle N+1.
- Word accepted at edge M: `chain_en` = 1 and `chain_data` = `word_in[0]` during cycle M+1. The chain samples that bit at edge M+2.
- A full word occupies WORD_WIDTH consecutive `chain_en`-high cycles, followed by at least one LOAD cycle with `chain_en` low.
- Throughput with `word_valid` held high: WORD_WIDTH bits per WORD_WIDTH+1 cycles.
- The last SHIFT cycle is followed by DONE on the next cycle. `done` rises in the same cycle that `chain_en` falls.
- Total `chain_en`-high cycles per load is exactly CHAIN_LENGTH.

## Test plan
- Reset: assert `sys_reset` asynchronously between edges → all outputs 0 immediately and the FSM is in IDLE.
- Exact fit, CHAIN_LENGTH=16, WORD_WIDTH=8, words 0xA5 then 0x3C → `chain_data` sequence 1,0,1,0,0,1,0,1, one gap, then 0,0,1,1,1,1,0,0. That is 16 `chain_en` cycles, `bits_sent` = 16, and `done` = 1.
- Partial final word, CHAIN_LENGTH=20, words 0xFF, 0x00, 0xF3 → 20 enabled bits, with the last four bits 1,1,0,0. `word_ready` is never reasserted after the third word. A reference 20-bit shift-chain model matches.
- Stall: hold `word_valid` low for 10 cycles in LOAD → `chain_en` stays 0, `bits_sent` is unchanged, and shifting resumes correctly afterwards.
- Ignored inputs: pulse `start` and `word_valid` mid-SHIFT → no state change and no extra word consumed; the total stays CHAIN_LENGTH.
- Reset mid-load after 5 bits → IDLE. A following `start` plus a full word sequence reloads CHAIN_LENGTH bits with `bits_sent` starting from 0.

Source files
------------

// File: rtl/config_loader.sv
// Serial configuration-chain loader: accepts words over valid/ready and shifts
// exactly CHAIN_LENGTH bits LSB-first onto the chain with a per-bit enable.
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 64,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1),
  parameter int BIT_WIDTH    = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  config_clk,
  input  logic                  sys_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  bits_sent
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
  logic [BIT_WIDTH-1:0]  bit_cnt, bit_cnt_nxt;
  logic [CNT_WIDTH-1:0]  bits_nxt;

  // Bits to take from the next word: a full word, or only what the chain still needs.
  function automatic logic [BIT_WIDTH-1:0] word_bits(input logic [CNT_WIDTH-1:0] sent);
    int remain;
    remain = CHAIN_LENGTH - int'(sent);
    if (remain >= WORD_WIDTH) return BIT_WIDTH'(WORD_WIDTH);
    else                      return BIT_WIDTH'(remain);
  endfunction

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    bits_nxt    = bits_sent;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = LOAD;
          bits_nxt  = '0;
        end
      end
      LOAD: begin
        if (word_valid) begin
          shreg_nxt   = word_in;
          bit_cnt_nxt = word_bits(bits_sent);
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_nxt   = shreg >> 1;
        bit_cnt_nxt = bit_cnt - BIT_WIDTH'(1);
        bits_nxt    = bits_sent + CNT_WIDTH'(1);
        if (bit_cnt == BIT_WIDTH'(1))
          state_nxt = (bits_nxt == CNT_WIDTH'(CHAIN_LENGTH)) ? DONE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and chain outputs; chain_en/chain_data are registered from next state.
  always_ff @(posedge config_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bits_sent  <= '0;
      chain_en   <= 1'b0;
      chain_data <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      bits_sent  <= bits_nxt;
      chain_en   <= (state_nxt == SHIFT);
      chain_data <= (state_nxt == SHIFT) & shreg_nxt[0];
    end
  end

  always_ff @(posedge config_clk) begin
    shreg <= shreg_nxt;
  end

  assign word_ready = (state == LOAD);
  assign busy       = (state == LOAD) || (state == SHIFT);
  assign done       = (state == DONE);

endmodule
